// File: rtl/router_sequencer.sv
// Controller-side initiator for the Router: stores a 1-16 byte burst into
// consecutive Router slots, then forwards it back out to a downstream strobe.
module router_sequencer #(
  parameter int RX_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] base_addr,
  input  logic [3:0] count,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] dp_bus,
  output logic [3:0] inAddr,
  output logic [3:0] outAddr,
  output logic       st_router,
  output logic       fw_router,
  input  logic       acknowledge,
  input  logic       received,
  input  logic [7:0] r_out,
  output logic [7:0] dst_data,
  output logic       dst_valid,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, STORE, ST_WAIT, FWD, FWD_CAP, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [3:0]      base_q, base_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      idx_q, idx_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [7:0]      dp_bus_q, dp_bus_d;
  logic [3:0]      in_addr_q, in_addr_d;
  logic [3:0]      out_addr_q, out_addr_d;
  logic            st_router_q, st_router_d;
  logic            fw_router_q, fw_router_d;
  logic [7:0]      dst_data_q, dst_data_d;
  logic            dst_valid_q, dst_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    dp_bus_d    = dp_bus_q;
    in_addr_d   = in_addr_q;
    out_addr_d  = out_addr_q;
    dst_data_d  = dst_data_q;
    error_d     = error_q;
    st_router_d = 1'b0;
    fw_router_d = 1'b0;
    dst_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start && acknowledge) begin
        state_d = STORE;
        base_d  = base_addr;
        len_d   = (count == 4'd0) ? 5'd16 : {1'b0, count};
        idx_d   = 5'd0;
        error_d = 1'b0;
      end
      STORE: if (src_valid) begin
        dp_bus_d    = src_data;
        in_addr_d   = base_q + idx_q[3:0];
        st_router_d = 1'b1;
        wait_d      = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (received) begin
          if (idx_q + 5'd1 == len_q) begin
            idx_d       = 5'd0;
            out_addr_d  = base_q;
            fw_router_d = 1'b1;
            state_d     = FWD;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = STORE;
          end
        end else if (wait_q == TW'(RX_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FWD: state_d = FWD_CAP;
      FWD_CAP: begin
        // r_out reflects the slot requested by the previous cycle's fw_router
        dst_data_d  = r_out;
        dst_valid_d = 1'b1;
        idx_d       = idx_q + 5'd1;
        if (idx_q + 5'd1 < len_q) begin
          out_addr_d  = base_q + idx_q[3:0] + 4'd1;
          fw_router_d = 1'b1;
          state_d     = FWD;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      dp_bus_q    <= '0;
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      st_router_q <= 1'b0;
      fw_router_q <= 1'b0;
      dst_data_q  <= '0;
      dst_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      dp_bus_q    <= dp_bus_d;
      in_addr_q   <= in_addr_d;
      out_addr_q  <= out_addr_d;
      st_router_q <= st_router_d;
      fw_router_q <= fw_router_d;
      dst_data_q  <= dst_data_d;
      dst_valid_q <= dst_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign src_ready = (state_q == STORE);
  assign dp_bus    = dp_bus_q;
  assign inAddr    = in_addr_q;
  assign outAddr   = out_addr_q;
  assign st_router = st_router_q;
  assign fw_router = fw_router_q;
  assign dst_data  = dst_data_q;
  assign dst_valid = dst_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_router_sequencer.sv
// Bench for router_sequencer: attaches a small Router model and a stalling byte
// source, then compares captured traffic against bursts derived from the rules.
module tb_router_sequencer;
  localparam int RX_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0, count = '0;
  logic [7:0] src_data = '0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [7:0] dp_bus;
  logic [3:0] inAddr, outAddr;
  logic       st_router, fw_router;
  logic       acknowledge = 1'b1;
  logic       received;
  logic [7:0] r_out = '0;
  logic [7:0] dst_data;
  logic       dst_valid, busy, done, error;

  int checks = 0;
  int errors = 0;

  router_sequencer #(.RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dp_bus(dp_bus), .inAddr(inAddr), .outAddr(outAddr),
    .st_router(st_router), .fw_router(fw_router), .acknowledge(acknowledge),
    .received(received), .r_out(r_out), .dst_data(dst_data), .dst_valid(dst_valid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Router model: store on st_router, present slot contents the cycle after fw_router
  logic [7:0] mem [16];
  logic       st_d1 = 1'b0;
  int         n_st = 0;
  logic       late = 1'b0, drop_en = 1'b0;
  int         drop_k = 0, st_base = 0;
  always @(posedge clk) begin
    if (st_router) mem[inAddr] <= dp_bus;
    if (fw_router) r_out <= mem[outAddr];
    st_d1 <= st_router;
    if (st_router) n_st <= n_st + 1;
  end
  assign received = late ? st_d1 : (st_router && !(drop_en && (n_st - st_base) == drop_k));

  // Byte source with an optional idle gap after each accepted byte
  logic [7:0] src_bytes [16];
  int xfers = 0, src_off = 0, src_n = 0, stall_len = 0, prev_x = 0, hold = 0;
  always @(posedge clk) if (src_valid && src_ready) xfers <= xfers + 1;
  always @(negedge clk) begin
    int k;
    if (xfers != prev_x) begin prev_x = xfers; hold = stall_len; end
    k = xfers - src_off;
    if (hold > 0) begin src_valid = 1'b0; hold--; end
    else if (k >= 0 && k < src_n) begin src_valid = 1'b1; src_data = src_bytes[k]; end
    else src_valid = 1'b0;
  end

  // Traffic monitor
  logic [11:0] st_q [$];
  logic [3:0]  fw_q [$];
  logic [7:0]  dst_q [$];
  int          done_t [$];
  int          viol = 0, err_rise = -1;
  logic        err_prev = 1'b0;
  always @(negedge clk) begin
    if (st_router) st_q.push_back({inAddr, dp_bus});
    if (fw_router) fw_q.push_back(outAddr);
    if (dst_valid) dst_q.push_back(dst_data);
    if (done) done_t.push_back(cyc);
    if ((st_router && fw_router) || (!busy && (st_router || fw_router || dst_valid))) viol++;
    if (error && !err_prev) err_rise = cyc;
    err_prev = error;
  end

  task automatic do_burst(input logic [3:0] b, input logic [3:0] c, input int stl,
                          input logic lt, output int t0, output bit to);
    int n;
    n = (c == 0) ? 16 : int'(c);
    @(negedge clk);
    src_off = xfers; src_n = n; stall_len = stl; late = lt; st_base = n_st;
    base_addr = b; count = c; start = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!busy) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [47:0] outs;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    outs = {src_ready, dp_bus, inAddr, outAddr, st_router, fw_router, dst_data, dst_valid, busy, done, error};
    checks++; if (outs !== 48'd0) begin errors++; $display("FAIL reset_init: got %h expected 0", outs); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
    src_off = xfers; src_n = 5; stall_len = 0; late = 1'b0; st_base = n_st;
    base_addr = 4'd3; count = 4'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_midburst_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    outs = {src_ready, dp_bus, inAddr, outAddr, st_router, fw_router, dst_data, dst_valid, busy, done, error};
    checks++; if (outs !== 48'd0) begin errors++; $display("FAIL reset_midburst: got %h expected 0", outs); end
    rst = 1'b0; src_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || src_ready !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b ready %b expected 0 0", busy, src_ready); end
  endtask

  task automatic test_basic;
    int t0, s0, f0, d0, n0; bit to;
    logic [7:0] exp_b [3];
    exp_b = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) src_bytes[i] = exp_b[i];
    s0 = st_q.size(); f0 = fw_q.size(); d0 = dst_q.size(); n0 = done_t.size();
    do_burst(4'd0, 4'd3, 0, 1'b0, t0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got busy stuck expected idle"); end
    checks++; if (st_q.size() - s0 != 3 || fw_q.size() - f0 != 3 || dst_q.size() - d0 != 3)
      begin errors++; $display("FAIL basic_counts: got st %0d fw %0d dst %0d expected 3 3 3", st_q.size() - s0, fw_q.size() - f0, dst_q.size() - d0); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (st_q[s0+i] !== {4'(i), exp_b[i]}) begin errors++; $display("FAIL basic_store[%0d]: got %h expected %h", i, st_q[s0+i], {4'(i), exp_b[i]}); end
      checks++; if (fw_q[f0+i] !== 4'(i)) begin errors++; $display("FAIL basic_fwd[%0d]: got %0d expected %0d", i, fw_q[f0+i], i); end
      checks++; if (dst_q[d0+i] !== exp_b[i]) begin errors++; $display("FAIL basic_dst[%0d]: got %h expected %h", i, dst_q[d0+i], exp_b[i]); end
    end
    checks++; if (done_t.size() - n0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_t.size() - n0); end
    else begin
      checks++; if (done_t[n0] - t0 + 1 != 13) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 13", done_t[n0] - t0 + 1); end
    end
  endtask

  task automatic test_wrap16;
    int t0, s0, f0, d0, n0, slot; bit to;
    for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
    s0 = st_q.size(); f0 = fw_q.size(); d0 = dst_q.size(); n0 = done_t.size();
    do_burst(4'd14, 4'd0, 0, 1'b0, t0, to);
    checks++; if (to || st_q.size() - s0 != 16 || fw_q.size() - f0 != 16 || dst_q.size() - d0 != 16)
      begin errors++; $display("FAIL wrap_counts: got st %0d fw %0d dst %0d expected 16 16 16", st_q.size() - s0, fw_q.size() - f0, dst_q.size() - d0); end
    else for (int i = 0; i < 16; i++) begin
      slot = (14 + i) % 16;
      checks++; if (st_q[s0+i] !== {4'(slot), src_bytes[i]}) begin errors++; $display("FAIL wrap_store[%0d]: got %h expected %h", i, st_q[s0+i], {4'(slot), src_bytes[i]}); end
      checks++; if (fw_q[f0+i] !== 4'(slot)) begin errors++; $display("FAIL wrap_fwd[%0d]: got %0d expected %0d", i, fw_q[f0+i], slot); end
      checks++; if (dst_q[d0+i] !== src_bytes[i]) begin errors++; $display("FAIL wrap_dst[%0d]: got %h expected %h", i, dst_q[d0+i], src_bytes[i]); end
    end
    checks++; if (done_t.size() - n0 != 1 || done_t[done_t.size()-1] - t0 + 1 != 65)
      begin errors++; $display("FAIL wrap_done: got count %0d expected 1 at cycle 65", done_t.size() - n0); end
  endtask

  task automatic test_stall;
    int t0, s0, d0, n0, slot; bit to;
    logic [3:0] b;
    b = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
    s0 = st_q.size(); d0 = dst_q.size(); n0 = done_t.size();
    do_burst(b, 4'd5, 3, 1'b1, t0, to);
    late = 1'b0; stall_len = 0;
    checks++; if (to || st_q.size() - s0 != 5 || dst_q.size() - d0 != 5)
      begin errors++; $display("FAIL stall_counts: got st %0d dst %0d expected 5 5", st_q.size() - s0, dst_q.size() - d0); end
    else for (int i = 0; i < 5; i++) begin
      slot = (int'(b) + i) % 16;
      checks++; if (st_q[s0+i] !== {4'(slot), src_bytes[i]}) begin errors++; $display("FAIL stall_store[%0d]: got %h expected %h", i, st_q[s0+i], {4'(slot), src_bytes[i]}); end
      checks++; if (dst_q[d0+i] !== src_bytes[i]) begin errors++; $display("FAIL stall_dst[%0d]: got %h expected %h", i, dst_q[d0+i], src_bytes[i]); end
    end
    // late received adds a cycle per store, the 3-cycle gap another; first byte has no gap
    checks++; if (done_t.size() - n0 != 1 || done_t[done_t.size()-1] - t0 + 1 != 30)
      begin errors++; $display("FAIL stall_done: got count %0d expected 1 at cycle 30", done_t.size() - n0); end
  endtask

  task automatic test_timeout;
    int t0, s0, f0, n0; bit to;
    for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
    s0 = st_q.size(); f0 = fw_q.size(); n0 = done_t.size();
    drop_en = 1'b1; drop_k = 1;
    do_burst(4'd7, 4'd3, 0, 1'b0, t0, to);
    drop_en = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL timeout_stuck: got busy expected idle"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b expected 1", error); end
    checks++; if (err_rise - t0 != 3 + RX_TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", err_rise - t0, 3 + RX_TIMEOUT); end
    checks++; if (st_q.size() - s0 != 2 || fw_q.size() - f0 != 0 || done_t.size() - n0 != 0)
      begin errors++; $display("FAIL timeout_traffic: got st %0d fw %0d done %0d expected 2 0 0", st_q.size() - s0, fw_q.size() - f0, done_t.size() - n0); end
    n0 = done_t.size();
    do_burst(4'd1, 4'd2, 0, 1'b0, t0, to);
    checks++; if (error !== 1'b0 || done_t.size() - n0 != 1) begin errors++; $display("FAIL timeout_clear: got error %b done %0d expected 0 1", error, done_t.size() - n0); end
  endtask

  task automatic test_gating;
    int s0, n0;
    for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
    s0 = st_q.size(); n0 = done_t.size();
    @(negedge clk);
    acknowledge = 1'b0;
    src_off = xfers; src_n = 2; stall_len = 0; late = 1'b0; st_base = n_st;
    base_addr = 4'd9; count = 4'd2; start = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || st_q.size() != s0) begin errors++; $display("FAIL gate_hold: got busy %b stores %0d expected 0 0", busy, st_q.size() - s0); end
    acknowledge = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_accept: got busy %b expected 1", busy); end
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    checks++; if (busy !== 1'b0 || done_t.size() - n0 != 1 || st_q.size() - s0 != 2)
      begin errors++; $display("FAIL gate_burst: got busy %b done %0d st %0d expected 0 1 2", busy, done_t.size() - n0, st_q.size() - s0); end
  endtask

  task automatic test_back_to_back;
    int t0, s0, f0, d0, n0, n, slot, stl; bit to; logic lt;
    logic [3:0] b, c;
    for (int r = 0; r < 6; r++) begin
      b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
      stl = $urandom_range(0, 2); lt = 1'($urandom_range(0, 1));
      n = (c == 0) ? 16 : int'(c);
      for (int i = 0; i < 16; i++) src_bytes[i] = 8'($urandom);
      s0 = st_q.size(); f0 = fw_q.size(); d0 = dst_q.size(); n0 = done_t.size();
      do_burst(b, c, stl, lt, t0, to);
      checks++; if (to || st_q.size() - s0 != n || fw_q.size() - f0 != n || dst_q.size() - d0 != n || done_t.size() - n0 != 1)
        begin errors++; $display("FAIL b2b%0d_counts: got st %0d fw %0d dst %0d done %0d expected %0d", r, st_q.size() - s0, fw_q.size() - f0, dst_q.size() - d0, done_t.size() - n0, n); end
      else begin
        for (int i = 0; i < n; i++) begin
          slot = (int'(b) + i) % 16;
          checks++; if (st_q[s0+i] !== {4'(slot), src_bytes[i]} || fw_q[f0+i] !== 4'(slot) || dst_q[d0+i] !== src_bytes[i])
            begin errors++; $display("FAIL b2b%0d_byte%0d: got st %h fw %0d dst %h expected slot %0d data %h", r, i, st_q[s0+i], fw_q[f0+i], dst_q[d0+i], slot, src_bytes[i]); end
        end
        if (stl == 0 && !lt) begin
          checks++; if (done_t[n0] - t0 + 1 != 4 * n + 1) begin errors++; $display("FAIL b2b%0d_done_cycle: got %0d expected %0d", r, done_t[n0] - t0 + 1, 4 * n + 1); end
        end
      end
    end
    late = 1'b0; stall_len = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap16();
    test_stall();
    test_timeout();
    test_gating();
    test_back_to_back();
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol_overlap: got %0d violations expected 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
